// File: rtl/hsv_core_mem_response_queue.sv
// In-order memory response queue: tracks up to DEPTH data-memory ops, matches AXI R/B beats to them, extends loads.
// Latency: head completion registers to out_* one cycle later; enqueue is visible at the head the following cycle.
// Backpressure: in_ready drops on full FIFO or MAX_OUT outstanding; commit_stall freezes out_* and head completion.
// Optional macro HSV_MEM_RESP_WRITE_ERR_EN: errored swallowed B beats set a sticky async_write_error.
module hsv_core_mem_response_queue #(
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2*DEPTH,
    parameter int TAG_W = 32,
    localparam int CNT_W = $clog2(MAX_OUT+1)
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_read,
    input  logic             in_is_memory,
    input  logic             in_sign_extend,
    input  logic             in_unaligned,
    input  logic [1:0]       in_size,
    input  logic [1:0]       in_shift,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             dmem_r_valid,
    output logic             dmem_r_ready,
    input  logic [31:0]      dmem_r_data,
    input  logic [1:0]       dmem_r_resp,
    input  logic             dmem_b_valid,
    output logic             dmem_b_ready,
    input  logic [1:0]       dmem_b_resp,
    input  logic             commit_mem,
    input  logic             commit_stall,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_result,
    output logic             out_trap,
    output logic             out_writeback,
    output logic [CNT_W-1:0] outstanding,
    output logic             async_write_error
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic             is_read;
        logic             is_memory;
        logic             sign_extend;
        logic             unaligned;
        logic [1:0]       size;
        logic [1:0]       shift;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0] count, uncommitted, discard_b, drop_r;
    logic [CNT_W-1:0] fl_reads, fl_iow;
    logic             head_vld, head_rd, head_iow, head_mw;
    logic             drop_act, disc_act;
    logic             r_fire, r_drop, r_head, b_fire, b_drop, b_head;
    logic             complete, enq, commit_dec, mw_done;
    logic             trap_nxt;
    logic [31:0]      shifted, ext_data;

    assign head     = mem[rd_ptr];
    assign head_vld = (count != '0);
    assign head_rd  = head_vld & head.is_read & ~head.unaligned;
    assign head_iow = head_vld & ~head.is_read & ~head.is_memory & ~head.unaligned;
    assign head_mw  = head_vld & ~head.is_read & head.is_memory & ~head.unaligned;
    assign drop_act = (drop_r != '0);
    assign disc_act = (discard_b != '0);

    assign outstanding = count + uncommitted + discard_b + drop_r;
    assign in_ready    = (count != CNT_W'(DEPTH)) & (outstanding < CNT_W'(MAX_OUT));

    // Orphaned beats are drained regardless of commit_stall.
    assign dmem_r_ready = drop_act | (head_rd & ~commit_stall);
    assign dmem_b_ready = disc_act | (head_iow & ~commit_stall);

    assign r_fire = dmem_r_valid & dmem_r_ready;
    assign r_drop = r_fire & drop_act;
    assign r_head = r_fire & ~drop_act;
    assign b_fire = dmem_b_valid & dmem_b_ready;
    assign b_drop = b_fire & disc_act;
    assign b_head = b_fire & ~disc_act;

    assign complete   = head_vld & ~commit_stall & (head.unaligned | head_mw | r_head | b_head);
    assign mw_done    = complete & head_mw & ~flush;
    assign enq        = in_valid & in_ready & ~flush;
    assign commit_dec = commit_mem & (uncommitted != '0);

    assign shifted = dmem_r_data >> {head.shift, 3'b000};

    always_comb begin
        ext_data = shifted;
        case (head.size)
            2'd0:    ext_data = {{24{head.sign_extend & shifted[7]}}, shifted[7:0]};
            2'd1:    ext_data = {{16{head.sign_extend & shifted[15]}}, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        trap_nxt = 1'b0;
        if (head.unaligned)
            trap_nxt = 1'b1;
        else if (head.is_read)
            trap_nxt = (dmem_r_resp == 2'b10) | (dmem_r_resp == 2'b11);
        else if (!head.is_memory)
            trap_nxt = (dmem_b_resp == 2'b10) | (dmem_b_resp == 2'b11);
    end

    // Bus ops still owed a beat at flush time; a head beat accepted this cycle is already consumed.
    always_comb begin
        fl_reads = '0;
        fl_iow   = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count && !mem[idx].unaligned) begin
                if (mem[idx].is_read)
                    fl_reads = fl_reads + CNT_W'(1);
                else if (!mem[idx].is_memory)
                    fl_iow = fl_iow + CNT_W'(1);
            end
        end
        fl_reads = fl_reads - CNT_W'(r_head);
        fl_iow   = fl_iow - CNT_W'(b_head);
    end

    always_ff @(posedge clk_core) begin
        if (enq)
            mem[wr_ptr] <= '{in_is_read, in_is_memory, in_sign_extend, in_unaligned,
                             in_size, in_shift, in_tag};
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            uncommitted <= '0;
            discard_b   <= '0;
            drop_r      <= '0;
        end else begin
            drop_r    <= drop_r + (flush ? fl_reads : '0) - CNT_W'(r_drop);
            discard_b <= discard_b + (flush ? fl_iow + uncommitted : CNT_W'(commit_dec))
                         - CNT_W'(b_drop);
            if (flush) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                uncommitted <= '0;
            end else begin
                rd_ptr      <= rd_ptr + PTR_W'(complete);
                wr_ptr      <= wr_ptr + PTR_W'(enq);
                count       <= count + CNT_W'(enq) - CNT_W'(complete);
                uncommitted <= uncommitted + CNT_W'(mw_done) - CNT_W'(commit_dec);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_result    <= '0;
            out_trap      <= 1'b0;
            out_writeback <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!commit_stall) begin
            out_valid <= complete;
            if (complete) begin
                out_tag       <= head.tag;
                out_result    <= ext_data;
                out_trap      <= trap_nxt;
                out_writeback <= head.is_read & ~head.unaligned;
            end
        end
    end

`ifdef HSV_MEM_RESP_WRITE_ERR_EN
    always_ff @(posedge clk_core) begin
        if (rst_core)
            async_write_error <= 1'b0;
        else if (b_drop && (dmem_b_resp == 2'b10 || dmem_b_resp == 2'b11))
            async_write_error <= 1'b1;
    end
`else
    assign async_write_error = 1'b0;
`endif

endmodule

// File: tb/tb_hsv_core_mem_response_queue.sv
// Directed bench for hsv_core_mem_response_queue (DEPTH=4, TAG_W=32) with immediate-assertion checks.
module tb_hsv_core_mem_response_queue;
    logic        clk_core = 1'b0;
    logic        rst_core, flush, in_valid, in_ready;
    logic        in_is_read, in_is_memory, in_sign_extend, in_unaligned;
    logic [1:0]  in_size, in_shift;
    logic [31:0] in_tag;
    logic        dmem_r_valid, dmem_r_ready;
    logic [31:0] dmem_r_data;
    logic [1:0]  dmem_r_resp;
    logic        dmem_b_valid, dmem_b_ready;
    logic [1:0]  dmem_b_resp;
    logic        commit_mem, commit_stall;
    logic        out_valid, out_trap, out_writeback, async_write_error;
    logic [31:0] out_tag, out_result;
    logic [3:0]  outstanding;

    int errors = 0;
    int checks = 0;
    logic exp_awe;

    hsv_core_mem_response_queue dut (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_read(in_is_read), .in_is_memory(in_is_memory),
        .in_sign_extend(in_sign_extend), .in_unaligned(in_unaligned),
        .in_size(in_size), .in_shift(in_shift), .in_tag(in_tag),
        .dmem_r_valid(dmem_r_valid), .dmem_r_ready(dmem_r_ready),
        .dmem_r_data(dmem_r_data), .dmem_r_resp(dmem_r_resp),
        .dmem_b_valid(dmem_b_valid), .dmem_b_ready(dmem_b_ready), .dmem_b_resp(dmem_b_resp),
        .commit_mem(commit_mem), .commit_stall(commit_stall),
        .out_valid(out_valid), .out_tag(out_tag), .out_result(out_result),
        .out_trap(out_trap), .out_writeback(out_writeback),
        .outstanding(outstanding), .async_write_error(async_write_error)
    );

    always #5 clk_core = ~clk_core;

    task automatic cyc;
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle enqueue; consecutive calls give back-to-back enqueues.
    task automatic enq(input logic rd, input logic memop, input logic sx, input logic un,
                       input logic [1:0] sz, input logic [1:0] sh, input logic [31:0] tg);
        in_valid = 1'b1; in_is_read = rd; in_is_memory = memop; in_sign_extend = sx;
        in_unaligned = un; in_size = sz; in_shift = sh; in_tag = tg;
        cyc;
        in_valid = 1'b0;
    endtask

    logic [31:0] rdat [4];
    logic [31:0] rexp [4];

    initial begin
        rst_core = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_is_read = 1'b0; in_is_memory = 1'b0; in_sign_extend = 1'b0; in_unaligned = 1'b0;
        in_size = 2'd0; in_shift = 2'd0; in_tag = '0;
        dmem_r_valid = 1'b0; dmem_r_data = '0; dmem_r_resp = 2'd0;
        dmem_b_valid = 1'b0; dmem_b_resp = 2'd0;
        commit_mem = 1'b0; commit_stall = 1'b0;
        cyc; cyc;
        rst_core = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_trap_wb", {out_trap, out_writeback}, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_readies", {dmem_r_ready, dmem_b_ready}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_awe", async_write_error, 0);

        // lb, shift 2
        enq(1, 1, 1, 0, 2'd0, 2'd2, 32'h0000_0001);
        dmem_r_valid = 1'b1; dmem_r_data = 32'h0080_0000; dmem_r_resp = 2'd0;
        #1 chk("lb_r_ready", dmem_r_ready, 1);
        cyc;
        dmem_r_valid = 1'b0;
        chk("lb_valid", out_valid, 1);
        chk("lb_result", out_result, 32'hFFFF_FF80);
        chk("lb_trap_wb", {out_trap, out_writeback}, 2'b01);
        chk("lb_tag", out_tag, 32'h0000_0001);

        // lbu, same data
        enq(1, 1, 0, 0, 2'd0, 2'd2, 32'h0000_0002);
        chk("lbu_pre_valid", out_valid, 0);
        dmem_r_valid = 1'b1;
        cyc;
        dmem_r_valid = 1'b0;
        chk("lbu_valid", out_valid, 1);
        chk("lbu_result", out_result, 32'h0000_0080);
        cyc;
        chk("lbu_valid_drop", out_valid, 0);

        // Four back-to-back reads fill the FIFO
        enq(1, 1, 0, 0, 2'd2, 2'd0, 32'h10);
        enq(1, 1, 1, 0, 2'd1, 2'd2, 32'h11);
        enq(1, 1, 0, 0, 2'd1, 2'd0, 32'h12);
        enq(1, 1, 1, 0, 2'd0, 2'd1, 32'h13);
        chk("full_in_ready", in_ready, 0);
        chk("full_outstanding", outstanding, 4);
        rdat[0] = 32'h1234_5678; rexp[0] = 32'h1234_5678;
        rdat[1] = 32'h8001_0000; rexp[1] = 32'hFFFF_8001;
        rdat[2] = 32'h0000_F00D; rexp[2] = 32'h0000_F00D;
        rdat[3] = 32'h0000_7F00; rexp[3] = 32'h0000_007F;
        for (int k = 0; k < 4; k++) begin
            dmem_r_valid = 1'b1; dmem_r_data = rdat[k];
            cyc;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", out_result, rexp[k]);
            chk("b2b_tag", out_tag, 32'h10 + k);
        end
        dmem_r_valid = 1'b0;
        cyc;
        chk("b2b_idle", out_valid, 0);
        chk("b2b_outstanding", outstanding, 0);

        // Two posted memory writes, committed, B beats swallowed
        enq(0, 1, 0, 0, 2'd2, 2'd0, 32'h20);
        enq(0, 1, 0, 0, 2'd2, 2'd0, 32'h21);
        chk("mw1_valid", out_valid, 1);
        chk("mw1_trap_wb", {out_trap, out_writeback}, 0);
        cyc;
        chk("mw2_tag", out_tag, 32'h21);
        chk("mw_uncommitted", outstanding, 2);
        chk("mw_b_ready_pre", dmem_b_ready, 0);
        commit_mem = 1'b1;
        cyc; cyc;
        commit_mem = 1'b0;
        chk("mw_discard_out", outstanding, 2);
        chk("mw_b_ready", dmem_b_ready, 1);
        dmem_b_valid = 1'b1; dmem_b_resp = 2'd0;
        cyc;
        chk("mw_b1_outstanding", outstanding, 1);
        chk("mw_b1_no_out", out_valid, 0);
        dmem_b_resp = 2'd2;
        cyc;
        dmem_b_valid = 1'b0; dmem_b_resp = 2'd0;
        chk("mw_b2_outstanding", outstanding, 0);
        chk("mw_b2_no_out", out_valid, 0);
        chk("mw_b_ready_post", dmem_b_ready, 0);
`ifdef HSV_MEM_RESP_WRITE_ERR_EN
        exp_awe = 1'b1;
`else
        exp_awe = 1'b0;
`endif
        chk("mw_async_err", async_write_error, exp_awe);

        // Flush with three reads pending, then drain and a fresh read
        enq(1, 1, 0, 0, 2'd2, 2'd0, 32'h30);
        enq(1, 1, 0, 0, 2'd2, 2'd0, 32'h31);
        enq(1, 1, 0, 0, 2'd2, 2'd0, 32'h32);
        flush = 1'b1;
        cyc;
        flush = 1'b0;
        chk("fl_outstanding", outstanding, 3);
        chk("fl_r_ready", dmem_r_ready, 1);
        chk("fl_valid", out_valid, 0);
        in_valid = 1'b1; in_is_read = 1'b1; in_is_memory = 1'b1; in_sign_extend = 1'b0;
        in_unaligned = 1'b0; in_size = 2'd2; in_shift = 2'd0; in_tag = 32'h99;
        dmem_r_valid = 1'b1; dmem_r_data = 32'h1111_1111;
        cyc;
        in_valid = 1'b0;
        chk("fl_d1_valid", out_valid, 0);
        chk("fl_d1_outstanding", outstanding, 3);
        dmem_r_data = 32'h2222_2222;
        cyc;
        chk("fl_d2_valid", out_valid, 0);
        dmem_r_data = 32'h3333_3333;
        cyc;
        chk("fl_d3_valid", out_valid, 0);
        chk("fl_d3_outstanding", outstanding, 1);
        dmem_r_data = 32'hCAFE_F00D;
        cyc;
        dmem_r_valid = 1'b0;
        chk("fl_new_valid", out_valid, 1);
        chk("fl_new_tag", out_tag, 32'h99);
        chk("fl_new_result", out_result, 32'hCAFE_F00D);
        cyc;
        chk("fl_outstanding_end", outstanding, 0);

        // Unaligned lw traps without a bus beat
        enq(1, 1, 0, 1, 2'd2, 2'd0, 32'h50);
        chk("un_r_ready_head", dmem_r_ready, 0);
        cyc;
        chk("un_r_ready_done", dmem_r_ready, 0);
        chk("un_valid", out_valid, 1);
        chk("un_trap_wb", {out_trap, out_writeback}, 2'b10);

        // I/O write with DECERR
        enq(0, 0, 0, 0, 2'd2, 2'd0, 32'h66);
        chk("io_b_ready", dmem_b_ready, 1);
        dmem_b_valid = 1'b1; dmem_b_resp = 2'd3;
        cyc;
        dmem_b_valid = 1'b0; dmem_b_resp = 2'd0;
        chk("io_valid", out_valid, 1);
        chk("io_trap_wb", {out_trap, out_writeback}, 2'b10);
        chk("io_tag", out_tag, 32'h66);

        // commit_stall for 3 cycles with R valid at the head
        commit_stall = 1'b1;
        dmem_r_valid = 1'b1; dmem_r_data = 32'h55AA_55AA; dmem_r_resp = 2'd0;
        enq(1, 1, 0, 0, 2'd2, 2'd0, 32'h77);
        for (int k = 0; k < 2; k++) begin
            chk("st_r_ready", dmem_r_ready, 0);
            chk("st_hold_valid", out_valid, 1);
            chk("st_hold_tag", out_tag, 32'h66);
            chk("st_hold_trap", out_trap, 1);
            cyc;
        end
        chk("st_r_ready_last", dmem_r_ready, 0);
        chk("st_hold_tag_last", out_tag, 32'h66);
        commit_stall = 1'b0;
        #1 chk("st_release_r_ready", dmem_r_ready, 1);
        cyc;
        dmem_r_valid = 1'b0;
        chk("st_valid", out_valid, 1);
        chk("st_tag", out_tag, 32'h77);
        chk("st_result", out_result, 32'h55AA_55AA);
        chk("st_trap_wb", {out_trap, out_writeback}, 2'b01);
        cyc;
        chk("st_outstanding_end", outstanding, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
